clk_alu_pipe: RTL and testbench
===============================

Name: clk_alu_pipe

Overview:
- Parametrised, pipelined successor to the registered two-operand logic core behind the tt_* top wrapper.
- Takes operands a and b plus an opcode, computes one of eight logic or arithmetic operations, and returns the result after STAGES clock cycles.
- Uses valid/ready handshakes on both sides with full back-pressure, and keeps an internal accumulator.
- Instantiated inside the tt_* wrapper, with ui_in, uio_in, uo_out and the uio pins mapped onto its ports.

Parameters:
- WIDTH, 8: operand, result and accumulator width in bits (legal range 2..32).
- STAGES, 2: pipeline depth, equal to latency in cycles (legal range 1..4).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- op  input  3  opcode, sampled together with a and b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- acc_clr  input  1  synchronous accumulator clear; independent of the handshake.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  result.
- carry  output  1  carry (ADD/ACC) or borrow (SUB) of the result beat; 0 for the logic ops.
- zero  output  1  high when y == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, stage data, accumulator, y, carry and zero go to 0.
  - in_ready reads 1 once reset is released.
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 ADD: a+b, carry = bit WIDTH of the sum.
  - 4 SUB: a-b, carry = borrow (a<b).
  - 5 NAND
  - 6 PASS: y = a.
  - 7 ACC: acc_next = acc + a, y = acc_next, carry = overflow out of acc. b is ignored.
- Arithmetic is unsigned and wraps modulo 2^WIDTH.
- Pipeline advance:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
- Accept: in_valid && in_ready.
  - The result is computed combinationally from the operands and written into stage 1.
  - Stage k moves to stage k+1 on each adv cycle; stage STAGES drives y, carry, zero and out_valid.
- When adv is 0, every stage holds, and y, carry and zero stay stable while out_valid is high.
- Bubbles: a stage with valid=0 still shifts on adv, so gaps in the input propagate as gaps at the output.
- Latency and throughput: with out_ready held at 1, a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES. Throughput is one beat per cycle.
- Accumulator:
  - Updated only on an accepted op 7.
  - acc_clr=1 sets acc to 0 at the clock edge.
  - acc_clr together with an accepted op 7 in the same cycle: the clear applies first, so y = a and acc becomes a.
  - Beats already in the pipeline are not affected by a clear.
- Unaccepted beats (in_valid with in_ready=0) have no side effects; in particular the accumulator is not updated.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Zero flag: computed from the final result at stage 1 and carried down the pipeline with it.

Optional Feature:
- Macro: CLK_ALU_SAT_EN.
- Defined:
  - ADD and ACC clamp to 2^WIDTH-1 on overflow.
  - SUB clamps to 0 on borrow.
  - carry still reports that the overflow or borrow occurred.
  - The accumulator stores the clamped value.
- Undefined: wrap-around arithmetic as specified above; no saturation logic is synthesised.

Test Plan:
1. Reset then stream: WIDTH=8, STAGES=2, out_ready=1. Send op0 a=0xF0 b=0x3C, op1, op2 back to back → out_valid in cycles N+2, N+3, N+4 with y=0x30, 0xFC, 0xCC; zero=0.
2. Arithmetic flags: op3 a=0xFF b=0x02 → y=0x01, carry=1. op4 a=0x05 b=0x05 → y=0x00, zero=1, carry=0. op4 a=0x01 b=0x02 → y=0xFF, carry=1. With CLK_ALU_SAT_EN: y=0xFF (ADD) and y=0x00 (SUB, a=0x01 b=0x02), carry=1 in both.
3. Back-pressure: hold out_ready=0 with 3 beats offered → in_ready drops once stages are full (after 2 accepted beats); y holds its first value. Release out_ready → beats emerge in order with no loss and no duplication.
4. Accumulator:
   - clear, then op7 a=0x10 three times → y=0x10, 0x20, 0x30.
   - acc_clr together with an op7 a=0x07 beat → y=0x07.
   - acc=0xF0, op7 a=0x20 → y=0x10, carry=1.
5. Reset mid-flight: 2 beats in the pipe, assert rst_n=0 for part of a cycle → out_valid=0 and y=0 immediately (asynchronous). After release, the accumulator reads 0 on the next op7 (a=0x01 → y=0x01).

Source files
------------

// File: rtl/clk_alu_pipe.sv
// -----------------------------------------------------------------------------
// clk_alu_pipe
//   Pipelined two-operand logic/arithmetic core with valid/ready handshakes
//   on both sides and an internal accumulator. The result of a beat is
//   computed combinationally at acceptance and then travels STAGES registers
//   down the pipeline together with its carry and zero flags.
//
//   Opcodes: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NAND, 6 PASS, 7 ACC.
//
//   Optional build macro: CLK_ALU_SAT_EN
//     When defined, ADD/ACC clamp to all-ones on overflow and SUB clamps to
//     zero on borrow; carry still flags the event and the accumulator keeps
//     the clamped value. Undefined (default): wrap-around arithmetic.
// -----------------------------------------------------------------------------
module clk_alu_pipe #(
    parameter int WIDTH  = 8,   // 2..32
    parameter int STAGES = 2    // 1..4, latency in cycles
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_NAND = 3'd5,
        OP_PASS = 3'd6,
        OP_ACC  = 3'd7
    } op_e;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic adv;
    logic accept;
    op_e  op_sel;

    // The whole pipeline moves whenever the output slot is empty or drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign op_sel   = op_e'(op);

    // -------------------------------------------------------------------------
    // Arithmetic datapath
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   acc_full;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] sub_y;
    logic [WIDTH-1:0] acc_y;

    // A clear in the same cycle as an accepted ACC applies first, so the
    // beat sees an accumulator of zero.
    assign acc_base = acc_clr ? '0 : acc_q;

    // Extend by one bit so the top bit is the carry (ADD/ACC) or borrow (SUB).
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign acc_full = {1'b0, acc_base} + {1'b0, a};

`ifdef CLK_ALU_SAT_EN
    // Clamp on overflow / borrow; the carry bit still reports the event.
    assign add_y = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
    assign sub_y = sub_full[WIDTH] ? {WIDTH{1'b0}} : sub_full[WIDTH-1:0];
    assign acc_y = acc_full[WIDTH] ? {WIDTH{1'b1}} : acc_full[WIDTH-1:0];
`else
    // Wrap modulo 2^WIDTH.
    assign add_y = add_full[WIDTH-1:0];
    assign sub_y = sub_full[WIDTH-1:0];
    assign acc_y = acc_full[WIDTH-1:0];
`endif

    logic [WIDTH-1:0] res_y;
    logic             res_c;

    // Select the stage-1 result and its carry from the opcode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, otherwise any path that skips an assignment infers a latch.
        res_y = '0;
        res_c = 1'b0;
        case (op_sel)
            OP_AND:  res_y = a & b;
            OP_OR:   res_y = a | b;
            OP_XOR:  res_y = a ^ b;
            OP_ADD: begin
                res_y = add_y;
                res_c = add_full[WIDTH];
            end
            OP_SUB: begin
                res_y = sub_y;
                res_c = sub_full[WIDTH];
            end
            OP_NAND: res_y = ~(a & b);
            OP_PASS: res_y = a;
            OP_ACC: begin
                res_y = acc_y;
                res_c = acc_full[WIDTH];
            end
            default: begin
                res_y = '0;
                res_c = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator
    // -------------------------------------------------------------------------
    // Update on an accepted ACC beat (clear already folded into acc_base),
    // otherwise honour a standalone clear. Unaccepted beats leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept && op_sel == OP_ACC) begin
            acc_q <= acc_y;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline stages
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] z_q;
    logic [WIDTH-1:0]  y_q [STAGES];

    // Shift every stage on adv; stage 0 takes a new result only on accept,
    // so an empty input slot becomes a bubble that flows to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            z_q   <= '0;
            // NOTE: the stage data registers are reset too (not just the
            // valid bits) because y/carry/zero must read 0 straight out of
            // reset; the array is small and register-based, not a RAM.
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= accept;
            if (accept) begin
                y_q[0] <= res_y;
                c_q[0] <= res_c;
                z_q[0] <= (res_y == '0);
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                y_q[k]   <= y_q[k-1];
                c_q[k]   <= c_q[k-1];
                z_q[k]   <= z_q[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from the last stage
    // -------------------------------------------------------------------------
    assign out_valid = vld_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign zero      = z_q[STAGES-1];

endmodule

// File: tb/tb_clk_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_clk_alu_pipe
//   Directed bench for clk_alu_pipe at WIDTH=8, STAGES=2. Each scenario task
//   drives its own vectors and compares against hand-computed values.
//   Honours CLK_ALU_SAT_EN for the saturating expectations.
// -----------------------------------------------------------------------------
module tb_clk_alu_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             zero;

    int tests_run    = 0;
    int tests_failed = 0;

    clk_alu_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op       = 3'd0;
        a        = 8'h00;
        b        = 8'h00;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        acc_clr   = 1'b0;
        idle();
        tick();
        tick();
        tests_run++;
        if ({out_valid, y, carry, zero} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b y=%h c=%b z=%b, want all 0",
                     out_valid, y, carry, zero);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stream();
        logic [7:0] exp_y [3];
        exp_y[0] = 8'h30;
        exp_y[1] = 8'hFC;
        exp_y[2] = 8'hCC;
        out_ready = 1'b1;
        beat(3'd0, 8'hF0, 8'h3C);
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latency: out_valid=%b one cycle after accept, want 0", out_valid);
        end
        beat(3'd1, 8'hF0, 8'h3C);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) beat(3'd2, 8'hF0, 8'h3C);
            else        idle();
            tests_run++;
            if (out_valid !== 1'b1 || y !== exp_y[i] || zero !== 1'b0 || carry !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_beat%0d: got v=%b y=%h z=%b c=%b, want v=1 y=%h z=0 c=0",
                         i, out_valid, y, zero, carry, exp_y[i]);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_drain: out_valid=%b after last beat, want 0", out_valid);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_arith();
        logic [2:0] v_op [3];
        logic [7:0] v_a  [3];
        logic [7:0] v_b  [3];
        logic [7:0] v_y  [3];
        logic       v_c  [3];
        v_op[0] = 3'd3; v_a[0] = 8'hFF; v_b[0] = 8'h02; v_c[0] = 1'b1;
        v_op[1] = 3'd4; v_a[1] = 8'h05; v_b[1] = 8'h05; v_c[1] = 1'b0;
        v_op[2] = 3'd4; v_a[2] = 8'h01; v_b[2] = 8'h02; v_c[2] = 1'b1;
`ifdef CLK_ALU_SAT_EN
        v_y[0] = 8'hFF;
        v_y[1] = 8'h00;
        v_y[2] = 8'h00;
`else
        v_y[0] = 8'h01;
        v_y[1] = 8'h00;
        v_y[2] = 8'hFF;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(v_op[i], v_a[i], v_b[i]);
            tick();
            idle();
            for (int s = 1; s < STAGES; s++) tick();
            tests_run++;
            if (out_valid !== 1'b1 || y !== v_y[i] || carry !== v_c[i]
                || zero !== (v_y[i] == 8'h00)) begin
                tests_failed++;
                $display("FAIL arith%0d: got v=%b y=%h c=%b z=%b, want v=1 y=%h c=%b z=%b",
                         i, out_valid, y, carry, zero, v_y[i], v_c[i], (v_y[i] == 8'h00));
            end
        end
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_pressure();
        out_ready = 1'b0;
        beat(3'd6, 8'h11, 8'h00);
        tick();
        beat(3'd6, 8'h22, 8'h00);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ready_second: got %b, want 1", in_ready);
        end
        tick();
        beat(3'd6, 8'h33, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h11) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b y=%h, want rdy=0 v=1 y=11",
                         i, in_ready, out_valid, y);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b, want 1", in_ready);
        end
        tick();
        idle();
        tests_run++;
        if (out_valid !== 1'b1 || y !== 8'h22) begin
            tests_failed++;
            $display("FAIL bp_order_b: got v=%b y=%h, want v=1 y=22", out_valid, y);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || y !== 8'h33) begin
            tests_failed++;
            $display("FAIL bp_order_c: got v=%b y=%h, want v=1 y=33", out_valid, y);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_no_dup: got v=%b y=%h, want v=0", out_valid, y);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_accumulator();
        logic [7:0] exp_y [3];
        exp_y[0] = 8'h10;
        exp_y[1] = 8'h20;
        exp_y[2] = 8'h30;
        out_ready = 1'b1;
        idle();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        beat(3'd7, 8'h10, 8'hAA);
        tick();
        beat(3'd7, 8'h10, 8'h55);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) beat(3'd7, 8'h10, 8'h00);
            else        idle();
            tests_run++;
            if (out_valid !== 1'b1 || y !== exp_y[i] || carry !== 1'b0) begin
                tests_failed++;
                $display("FAIL acc_run%0d: got v=%b y=%h c=%b, want v=1 y=%h c=0",
                         i, out_valid, y, carry, exp_y[i]);
            end
            tick();
        end

        // Clear together with an accepted ACC: clear wins first.
        beat(3'd7, 8'h07, 8'h00);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        idle();
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || y !== 8'h07) begin
            tests_failed++;
            $display("FAIL acc_clr_same: got v=%b y=%h, want v=1 y=07", out_valid, y);
        end

        // Bring acc to 0xF0 (0x07 + 0xE9), then overflow with 0x20.
        beat(3'd7, 8'hE9, 8'h00);
        tick();
        beat(3'd7, 8'h20, 8'h00);
        tick();
        idle();
        tests_run++;
        if (y !== 8'hF0 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL acc_setup: got y=%h c=%b, want y=f0 c=0", y, carry);
        end
        tick();
        tests_run++;
`ifdef CLK_ALU_SAT_EN
        if (out_valid !== 1'b1 || y !== 8'hFF || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL acc_overflow: got v=%b y=%h c=%b, want v=1 y=ff c=1", out_valid, y, carry);
        end
`else
        if (out_valid !== 1'b1 || y !== 8'h10 || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL acc_overflow: got v=%b y=%h c=%b, want v=1 y=10 c=1", out_valid, y, carry);
        end
`endif
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midflight();
        out_ready = 1'b1;
        beat(3'd6, 8'h55, 8'h00);
        tick();
        beat(3'd6, 8'h66, 8'h00);
        tick();
        idle();
        tests_run++;
        if (out_valid !== 1'b1 || y !== 8'h55) begin
            tests_failed++;
            $display("FAIL midrst_pre: got v=%b y=%h, want v=1 y=55", out_valid, y);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || y !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_async: got v=%b y=%h, want v=0 y=00", out_valid, y);
        end
        #1;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_discard: got v=%b y=%h, want v=0", out_valid, y);
        end
        beat(3'd7, 8'h01, 8'h00);
        tick();
        idle();
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || y !== 8'h01 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_acc: got v=%b y=%h c=%b, want v=1 y=01 c=0", out_valid, y, carry);
        end
        tick();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_stream();
        test_arith();
        test_back_pressure();
        test_accumulator();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
